wave_usb_reader: RTL and testbench
==================================

// Module: wave_usb_reader
// PURPOSE
//   Readout side of the waveform memory. On a transfer command, reads LEN 10-bit
//   samples from the synchronous waveform RAM and writes each one to the FT245-type
//   USB FIFO as two bytes, high byte first, with TXE# flow control.
//   Sits between the command decoder (command 5 = transfer, 2/4 = address clear) and the USB pins.
// PARAMETERS
//   AW       10   RAM address width; RADDR wraps modulo 2**AW
//   DW       10   sample width (DW<=16)
//   WR_PW    4    USB_WR high width in CLK cycles (>=1)
//   DEF_LEN  128  transfer length used when LEN==0 at START
// PORTS
//   CLK       in   1     system clock
//   RES       in   1     synchronous reset, active high
//   START     in   1     1-cycle pulse: begin transfer (ignored unless IDLE)
//   ADDR_CLR  in   1     1-cycle pulse: RADDR<=0 (honoured only in IDLE)
//   LEN       in   AW+1  sample count, sampled on accepted START
//   RADDR     out  AW    RAM read address (registered)
//   RDATA     in   DW    RAM read data, valid 1 cycle after RADDR
//   TXE_N     in   1     USB FIFO space, low = may write (asynchronous)
//   USB_D     out  8     USB data byte
//   USB_WR    out  1     USB write strobe; FIFO latches USB_D on falling edge
//   BUSY      out  1     high from cycle after accepted START until DONE
//   DONE      out  1     1-cycle pulse: transfer finished
// BEHAVIOUR
//   Reset (RES=1 at a CLK edge, in any state, including mid-strobe): next cycle
//     state=IDLE, RADDR=0, USB_D=0, USB_WR=0, BUSY=0, DONE=0, count=0.
//   TXE_N passes a 2-FF synchronizer (txe_s); all decisions use txe_s (+2 cycles latency).
//   FSM: IDLE -> FETCH -> CAPT -> WAIT -> STRB -> RECOV -> (WAIT | FETCH | IDLE)
//   IDLE : START -> latch cnt=(LEN==0?DEF_LEN:LEN), byte_sel=H, go FETCH, BUSY=1.
//   FETCH: RADDR is presented; 1 cycle.
//   CAPT : sample<=RDATA; 1 cycle.
//   WAIT : USB_D = byte_sel==H ? {zero-pad, sample[DW-1:8]} : sample[7:0];
//          stays here while txe_s=1 (indefinitely; no timeout); txe_s=0 -> STRB.
//   STRB : USB_WR=1 for exactly WR_PW cycles; USB_D is held stable.
//   RECOV: USB_WR=0 for 1 cycle, USB_D still held (hold time past falling edge).
//          byte_sel==H -> byte_sel=L, go WAIT.
//          byte_sel==L -> RADDR<=RADDR+1 (wraps), cnt<=cnt-1;
//          cnt was 1 -> DONE=1 this cycle, BUSY=0 next, go IDLE; else FETCH.
//   TXE_N rising during STRB does not shorten the strobe; it is only checked in WAIT.
//   RADDR is not cleared at transfer end: next transfer continues from the wrapped address
//     unless ADDR_CLR is given in IDLE. ADDR_CLR and START in the same IDLE cycle:
//     clear wins first, transfer starts at address 0.
//   START or ADDR_CLR while BUSY: ignored, no side effects.
//   Per sample with txe_s held 0: 2 + 2*(WR_PW+1) cycles (12 at WR_PW=4) plus WAIT entry cycles.
//   USB_WR never high outside STRB; exactly 2*cnt strobes per transfer.
// TESTING
//   1 Reset, RAM[k]=k*3, ADDR_CLR, START LEN=4, TXE_N=0 -> bytes 00,00,00,03,00,06,00,09;
//     8 strobes each 4 cycles wide; DONE once; RADDR=4 afterwards.
//   2 RAM[0]=10'h3A5, LEN=1, TXE_N=1 for 50 cycles then 0 -> no USB_WR while high;
//     then bytes 03,A5.
//   3 Toggle TXE_N between bytes -> WAIT stalls, data held, no strobe lost or duplicated.
//   4 RADDR=1022, LEN=4 -> reads 1022,1023,0,1; final RADDR=2.
//   5 LEN=0 -> 128 samples (256 strobes); START and ADDR_CLR mid-transfer ignored.
//   6 RES asserted during STRB -> USB_WR=0 next cycle, IDLE, RADDR=0; new START works.

Source files
------------

// File: rtl/wave_usb_reader.sv
// Waveform RAM readout into an FT245-style USB FIFO: each DW-bit sample goes out as two
// bytes (high first), each byte gated by the synchronized TXE# and strobed WR_PW cycles wide.
module wave_usb_reader #(
    parameter int AW      = 10,
    parameter int DW      = 10,
    parameter int WR_PW   = 4,
    parameter int DEF_LEN = 128
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          START,
    input  logic          ADDR_CLR,
    input  logic [AW:0]   LEN,
    output logic [AW-1:0] RADDR,
    input  logic [DW-1:0] RDATA,
    input  logic          TXE_N,
    output logic [7:0]    USB_D,
    output logic          USB_WR,
    output logic          BUSY,
    output logic          DONE
);

    localparam int PW_W = (WR_PW > 1) ? $clog2(WR_PW) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CAPT, S_WAIT, S_STRB, S_RECOV
    } state_t;

    state_t          state, state_nx;
    logic            txe_m, txe_s;
    logic [AW:0]     cnt;
    logic            byte_lo;
    logic [7:0]      sample_lo;
    logic [7:0]      rdata_hi;
    logic [PW_W-1:0] pw_cnt;
    logic            pw_last;
    logic            last_byte;

    assign pw_last   = (pw_cnt == PW_W'(WR_PW - 1));
    assign last_byte = byte_lo && (cnt == (AW+1)'(1));
    assign BUSY      = (state != S_IDLE);
    assign DONE      = (state == S_RECOV) && last_byte;

    // Upper sample bits zero-padded into the high byte
    always_comb begin
        rdata_hi = '0;
        rdata_hi[DW-9:0] = RDATA[DW-1:8];
    end

    always_ff @(posedge CLK) begin
        if (RES) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (START) state_nx = S_FETCH;
            S_FETCH: state_nx = S_CAPT;
            S_CAPT:  state_nx = S_WAIT;
            S_WAIT:  if (!txe_s) state_nx = S_STRB;
            S_STRB:  if (pw_last) state_nx = S_RECOV;
            S_RECOV: begin
                if (!byte_lo)          state_nx = S_WAIT;
                else if (last_byte)    state_nx = S_IDLE;
                else                   state_nx = S_FETCH;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // USB_D is loaded on entry to WAIT and left untouched through STRB and RECOV
    always_ff @(posedge CLK) begin
        if (RES) begin
            txe_m     <= 1'b1;
            txe_s     <= 1'b1;
            RADDR     <= '0;
            USB_D     <= '0;
            USB_WR    <= 1'b0;
            cnt       <= '0;
            byte_lo   <= 1'b0;
            sample_lo <= '0;
            pw_cnt    <= '0;
        end else begin
            txe_m  <= TXE_N;
            txe_s  <= txe_m;
            USB_WR <= (state_nx == S_STRB);
            case (state)
                S_IDLE: begin
                    if (ADDR_CLR) RADDR <= '0;
                    if (START) begin
                        cnt     <= (LEN == '0) ? (AW+1)'(DEF_LEN) : LEN;
                        byte_lo <= 1'b0;
                    end
                end
                S_CAPT: begin
                    sample_lo <= RDATA[7:0];
                    USB_D     <= rdata_hi;
                end
                S_STRB: pw_cnt <= pw_last ? '0 : pw_cnt + PW_W'(1);
                S_RECOV: begin
                    if (!byte_lo) begin
                        byte_lo <= 1'b1;
                        USB_D   <= sample_lo;
                    end else begin
                        byte_lo <= 1'b0;
                        RADDR   <= RADDR + AW'(1);
                        cnt     <= cnt - (AW+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_usb_reader.sv
// Self-checking bench for wave_usb_reader: table of transfers plus hand sequences,
// with a byte scoreboard checked at every USB_WR falling edge.
module tb_wave_usb_reader;

    localparam int AW    = 10;
    localparam int DW    = 10;
    localparam int WR_PW = 4;

    logic          CLK = 1'b0;
    logic          RES, START, ADDR_CLR, TXE_N;
    logic [AW:0]   LEN;
    logic [AW-1:0] RADDR;
    logic [DW-1:0] RDATA;
    logic [7:0]    USB_D;
    logic          USB_WR, BUSY, DONE;

    wave_usb_reader #(.AW(AW), .DW(DW), .WR_PW(WR_PW), .DEF_LEN(128)) dut (
        .CLK(CLK), .RES(RES), .START(START), .ADDR_CLR(ADDR_CLR), .LEN(LEN),
        .RADDR(RADDR), .RDATA(RDATA), .TXE_N(TXE_N), .USB_D(USB_D),
        .USB_WR(USB_WR), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge CLK) RDATA <= ram[RADDR];

    typedef struct {
        bit            clr;
        bit            toggle;
        bit            inject;
        logic [AW:0]   len;
        logic [AW-1:0] exp_addr;
        int            exp_strobes;
    } vec_t;

    vec_t          vecs [6];
    int            checks = 0;
    int            errors = 0;
    logic [7:0]    exp_q [$];
    int            strobe_cnt = 0;
    int            done_cnt = 0;
    bit            toggle_en = 0;
    logic [AW-1:0] model_addr = '0;

    logic          wr_prev = 1'b0;
    int            wr_width = 0;
    logic [7:0]    d_rise = '0;
    logic [7:0]    exp_byte;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Strobe monitor: width, byte value at rise and at fall, DONE pulse count
    always @(negedge CLK) begin
        if (RES) begin
            wr_prev  = 1'b0;
            wr_width = 0;
            exp_q.delete();
        end else begin
            if (DONE) done_cnt++;
            if (USB_WR && !BUSY) begin
                errors++;
                $display("[TB] FAIL wr_outside_busy: USB_WR=1 while BUSY=0");
            end
            if (USB_WR) begin
                if (!wr_prev) d_rise = USB_D;
                wr_width++;
            end else if (wr_prev) begin
                strobe_cnt++;
                checkOutput("strobe_width", wr_width, WR_PW);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_strobe", 1, 0);
                end else begin
                    exp_byte = exp_q.pop_front();
                    checkOutput("byte_at_rise", d_rise, exp_byte);
                    checkOutput("byte_at_fall", USB_D, exp_byte);
                end
                wr_width = 0;
            end
            wr_prev = USB_WR;
        end
    end

    always @(negedge CLK) if (toggle_en) TXE_N = ($urandom_range(0, 3) == 0);

    task automatic applyStimulus(input vec_t v);
        int n, cyc, s0, d0;
        logic [AW-1:0] a;
        n = (v.len == 0) ? 128 : int'(v.len);
        a = v.clr ? '0 : model_addr;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(8'(ram[a] >> 8));
            exp_q.push_back(ram[a][7:0]);
            a = a + 1'b1;
        end
        model_addr = a;
        s0 = strobe_cnt;
        d0 = done_cnt;
        toggle_en = v.toggle;
        if (!v.toggle) TXE_N = 1'b0;
        @(posedge CLK) #1;
        START = 1'b1; ADDR_CLR = v.clr; LEN = v.len;
        @(posedge CLK) #1;
        START = 1'b0; ADDR_CLR = 1'b0;
        checkOutput("busy_after_start", BUSY, 1);
        cyc = 0;
        while (BUSY && cyc < n * 60 + 100) begin
            @(posedge CLK) #1;
            cyc++;
            if (v.inject && cyc == 300) begin
                START = 1'b1; ADDR_CLR = 1'b1; LEN = 5;
            end else if (v.inject && cyc == 301) begin
                START = 1'b0; ADDR_CLR = 1'b0;
            end
        end
        checkOutput("busy_cleared", BUSY, 0);
        toggle_en = 0;
        TXE_N = 1'b0;
        repeat (2) @(posedge CLK) #1;
        checkOutput("final_raddr", RADDR, v.exp_addr);
        checkOutput("strobe_count", strobe_cnt - s0, v.exp_strobes);
        checkOutput("done_pulses", done_cnt - d0, 1);
        checkOutput("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int s0, cyc;
        //             clr  tog  inj  len       addr      strobes
        vecs[0] = '{1'b1, 1'b0, 1'b0, 11'd4,    10'd4,    8};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 11'd3,    10'd7,    6};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 11'd1022, 10'd1022, 2044};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 11'd4,    10'd2,    8};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 11'd0,    10'd130,  256};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 11'd2,    10'd2,    4};

        for (int k = 0; k < (1 << AW); k++) ram[k] = DW'(k * 3);

        RES = 1'b1; START = 1'b0; ADDR_CLR = 1'b0; LEN = '0; TXE_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RES = 1'b0;
        checkOutput("reset_raddr", RADDR, 0);
        checkOutput("reset_usb_wr", USB_WR, 0);
        checkOutput("reset_busy", BUSY, 0);
        checkOutput("reset_done", DONE, 0);
        checkOutput("reset_usb_d", USB_D, 0);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d len %0d", i, vecs[i].len);
            applyStimulus(vecs[i]);
        end

        // TXE# held high: transfer must stall in WAIT without strobing
        ram[0] = 10'h3A5;
        TXE_N = 1'b1;
        repeat (3) @(posedge CLK) #1;
        s0 = strobe_cnt;
        exp_q.push_back(8'h03);
        exp_q.push_back(8'hA5);
        START = 1'b1; ADDR_CLR = 1'b1; LEN = 11'd1;
        @(posedge CLK) #1;
        START = 1'b0; ADDR_CLR = 1'b0;
        repeat (50) @(posedge CLK) #1;
        checkOutput("stall_no_strobe", strobe_cnt - s0, 0);
        checkOutput("stall_usb_wr", USB_WR, 0);
        checkOutput("stall_busy", BUSY, 1);
        TXE_N = 1'b0;
        cyc = 0;
        while (BUSY && cyc < 200) begin
            @(posedge CLK) #1;
            cyc++;
        end
        repeat (2) @(posedge CLK) #1;
        checkOutput("stall_busy_cleared", BUSY, 0);
        checkOutput("stall_strobes", strobe_cnt - s0, 2);
        checkOutput("stall_raddr", RADDR, 1);
        checkOutput("stall_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a strobe, then a fresh transfer from address 0
        START = 1'b1; LEN = 11'd2;
        @(posedge CLK) #1;
        START = 1'b0;
        cyc = 0;
        while (!USB_WR && cyc < 200) begin
            @(posedge CLK) #1;
            cyc++;
        end
        checkOutput("strobe_seen_before_reset", USB_WR, 1);
        @(posedge CLK) #1;
        RES = 1'b1;
        @(posedge CLK) #1;
        RES = 1'b0;
        checkOutput("midreset_usb_wr", USB_WR, 0);
        checkOutput("midreset_busy", BUSY, 0);
        checkOutput("midreset_raddr", RADDR, 0);
        checkOutput("midreset_usb_d", USB_D, 0);
        model_addr = '0;
        applyStimulus('{1'b0, 1'b0, 1'b0, 11'd1, 10'd1, 2});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
